// File: rtl/reorder_buffer_if.sv
// Rename/ROB/free-list connection bundle: dispatch, two completion ports,
// dual retire release and occupancy status.
interface reorder_buffer_if #(
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 6,
    parameter int ARCH_W = 5
);
    logic              dispatch_valid;
    logic [TAG_W-1:0]  dispatch_phys_rd;
    logic [TAG_W-1:0]  dispatch_old_phys_rd;
    logic [ARCH_W-1:0] dispatch_arch_reg;
    logic              dispatch_is_store;
    logic              dispatch_ready;
    logic [IDX_W-1:0]  dispatch_rob_idx;

    logic              complete_valid_a;
    logic              complete_valid_b;
    logic [IDX_W-1:0]  complete_idx_a;
    logic [IDX_W-1:0]  complete_idx_b;

    logic              retire_valid1;
    logic              retire_valid2;
    logic [TAG_W-1:0]  retire_phys_reg1;
    logic [TAG_W-1:0]  retire_phys_reg2;
    logic [ARCH_W-1:0] retire_arch_reg1;
    logic [ARCH_W-1:0] retire_arch_reg2;
    logic [1:0]        retire_store;

    logic [IDX_W:0]    rob_count;
    logic              rob_empty;

    // Rename / completion side
    modport master (
        output dispatch_valid, dispatch_phys_rd, dispatch_old_phys_rd,
               dispatch_arch_reg, dispatch_is_store,
               complete_valid_a, complete_valid_b, complete_idx_a, complete_idx_b,
        input  dispatch_ready, dispatch_rob_idx,
               retire_valid1, retire_valid2, retire_phys_reg1, retire_phys_reg2,
               retire_arch_reg1, retire_arch_reg2, retire_store,
               rob_count, rob_empty
    );

    // Reorder buffer side
    modport slave (
        input  dispatch_valid, dispatch_phys_rd, dispatch_old_phys_rd,
               dispatch_arch_reg, dispatch_is_store,
               complete_valid_a, complete_valid_b, complete_idx_a, complete_idx_b,
        output dispatch_ready, dispatch_rob_idx,
               retire_valid1, retire_valid2, retire_phys_reg1, retire_phys_reg2,
               retire_arch_reg1, retire_arch_reg2, retire_store,
               rob_count, rob_empty
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue. Records dispatched instructions at the tail,
// marks them done on completion and retires up to two done entries per cycle
// from the head, releasing each one's displaced physical register.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 6,
    parameter int ARCH_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    reorder_buffer_if.slave rif
);
    logic [IDX_W-1:0]  head, tail, head1;
    logic [IDX_W:0]    count;

    logic [DEPTH-1:0]  ent_valid, ent_done, ent_store;
    logic [DEPTH-1:0]  valid_next, done_next;
    logic [TAG_W-1:0]  ent_old  [DEPTH];
    logic [ARCH_W-1:0] ent_arch [DEPTH];

    logic              r1, r2, accept, ready;
    logic [1:0]        n_ret;

    logic              rv1, rv2;
    logic [TAG_W-1:0]  rp1, rp2;
    logic [ARCH_W-1:0] ra1, ra2;
    logic [1:0]        rst_bits;

    assign head1  = head + 1'b1;
    assign r1     = ent_valid[head] & ent_done[head];
    assign r2     = r1 & ent_valid[head1] & ent_done[head1];
    // r2 implies r1, so r1 + r2 is {r2, r1 ^ r2}
    assign n_ret  = {r2, r1 ^ r2};
    assign ready  = count < (IDX_W+1)'(DEPTH);
    assign accept = rif.dispatch_valid & ready;

    assign rif.dispatch_ready   = ready;
    assign rif.dispatch_rob_idx = tail;
    assign rif.rob_count        = count;
    assign rif.rob_empty        = (count == '0);
    assign rif.retire_valid1    = rv1;
    assign rif.retire_valid2    = rv2;
    assign rif.retire_phys_reg1 = rp1;
    assign rif.retire_phys_reg2 = rp2;
    assign rif.retire_arch_reg1 = ra1;
    assign rif.retire_arch_reg2 = ra2;
    assign rif.retire_store     = rst_bits;

    // Next valid/done flags: completions on live entries, then retire clears,
    // then the tail write (the tail entry is never live while dispatch is ready).
    always_comb begin
        valid_next = ent_valid;
        done_next  = ent_done;
        if (rif.complete_valid_a && ent_valid[rif.complete_idx_a])
            done_next[rif.complete_idx_a] = 1'b1;
        if (rif.complete_valid_b && ent_valid[rif.complete_idx_b])
            done_next[rif.complete_idx_b] = 1'b1;
        if (r1) begin
            valid_next[head] = 1'b0;
            done_next[head]  = 1'b0;
        end
        if (r2) begin
            valid_next[head1] = 1'b0;
            done_next[head1]  = 1'b0;
        end
        if (accept) begin
            valid_next[tail] = 1'b1;
            done_next[tail]  = 1'b0;
        end
    end

    // Pointers, occupancy, entry flags and registered retire outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
            rv1       <= 1'b0;
            rv2       <= 1'b0;
            rp1       <= '0;
            rp2       <= '0;
            ra1       <= '0;
            ra2       <= '0;
            rst_bits  <= '0;
        end else begin
            ent_valid <= valid_next;
            ent_done  <= done_next;
            head      <= head + IDX_W'(n_ret);
            tail      <= tail + IDX_W'(accept);
            count     <= count + (IDX_W+1)'(accept) - (IDX_W+1)'(n_ret);
            rv1       <= r1 & ~ent_store[head];
            rv2       <= r2 & ~ent_store[head1];
            rst_bits  <= {r2 & ent_store[head1], r1 & ent_store[head]};
            if (r1) begin
                rp1 <= ent_old[head];
                ra1 <= ent_arch[head];
            end
            if (r2) begin
                rp2 <= ent_old[head1];
                ra2 <= ent_arch[head1];
            end
        end
    end

    // Payload of each accepted instruction, written at the tail.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            ent_old[tail]   <= rif.dispatch_old_phys_rd;
            ent_arch[tail]  <= rif.dispatch_arch_reg;
            ent_store[tail] <= rif.dispatch_is_store;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based in-order model predicts
// each retire cycle; a negedge monitor pops and compares whenever the DUT
// presents a retire.
module tb_reorder_buffer;
    localparam int DEPTH = 16;

    typedef struct {
        logic [3:0] idx;
        logic [5:0] phys;
        logic [5:0] old;
        logic [4:0] arch;
        bit         st;
        bit         done;
    } ent_t;

    typedef struct {
        bit         v1;
        bit         v2;
        logic [5:0] p1;
        logic [5:0] p2;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [1:0] st;
    } ret_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reorder_buffer_if #(.IDX_W(4), .TAG_W(6), .ARCH_W(5)) rif ();

    reorder_buffer #(.DEPTH(16), .IDX_W(4), .TAG_W(6), .ARCH_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .rif   (rif.slave)
    );

    ent_t       m_q[$];
    ret_t       exp_q[$];
    logic [3:0] m_tail = '0;
    logic [5:0] h_p1 = '0, h_p2 = '0;
    logic [4:0] h_a1 = '0, h_a2 = '0;
    int         checks = 0, errors = 0;
    int         ret_events = 0, ret_instr = 0;
    bit         started = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock cycle: drive inputs, check status outputs against the model,
    // advance the model, then pass the edge.
    task automatic step(bit rst_i, bit dv, logic [5:0] old, logic [4:0] arch, bit st,
                        bit cav, logic [3:0] cai, bit cbv, logic [3:0] cbi);
        ent_t e;
        ret_t r;
        bit   r1, r2, acc;
        reset                    = rst_i;
        rif.dispatch_valid       = dv;
        rif.dispatch_phys_rd     = st ? 6'h3F : 6'($urandom_range(32, 62));
        rif.dispatch_old_phys_rd = old;
        rif.dispatch_arch_reg    = arch;
        rif.dispatch_is_store    = st;
        rif.complete_valid_a     = cav;
        rif.complete_idx_a       = cai;
        rif.complete_valid_b     = cbv;
        rif.complete_idx_b       = cbi;

        check("rob_count", 32'(rif.rob_count), 32'(m_q.size()));
        check("dispatch_ready", 32'(rif.dispatch_ready), 32'(m_q.size() < DEPTH));
        check("rob_empty", 32'(rif.rob_empty), 32'(m_q.size() == 0));
        check("dispatch_rob_idx", 32'(rif.dispatch_rob_idx), 32'(m_tail));

        if (rst_i) begin
            m_q.delete();
            m_tail = '0;
            h_p1 = '0; h_p2 = '0; h_a1 = '0; h_a2 = '0;
        end else begin
            acc = dv && (m_q.size() < DEPTH);
            r1  = (m_q.size() > 0) && m_q[0].done;
            r2  = r1 && (m_q.size() > 1) && m_q[1].done;
            if (r1) begin
                r.v1 = !m_q[0].st;
                r.v2 = 1'b0;
                r.st = {1'b0, m_q[0].st};
                h_p1 = m_q[0].old;
                h_a1 = m_q[0].arch;
                if (r2) begin
                    r.v2    = !m_q[1].st;
                    r.st[1] = m_q[1].st;
                    h_p2    = m_q[1].old;
                    h_a2    = m_q[1].arch;
                end
                r.p1 = h_p1; r.a1 = h_a1; r.p2 = h_p2; r.a2 = h_a2;
                exp_q.push_back(r);
            end
            foreach (m_q[i]) begin
                if (cav && m_q[i].idx == cai) m_q[i].done = 1'b1;
                if (cbv && m_q[i].idx == cbi) m_q[i].done = 1'b1;
            end
            if (r1) void'(m_q.pop_front());
            if (r2) void'(m_q.pop_front());
            if (acc) begin
                e.idx  = m_tail;
                e.phys = rif.dispatch_phys_rd;
                e.old  = old;
                e.arch = arch;
                e.st   = st;
                e.done = 1'b0;
                m_q.push_back(e);
                m_tail = m_tail + 4'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(bit dv, logic [5:0] old, logic [4:0] arch, bit st,
                       bit cav, logic [3:0] cai, bit cbv, logic [3:0] cbi);
        step(1'b0, dv, old, arch, st, cav, cai, cbv, cbi);
    endtask

    task automatic idle(int n);
        repeat (n) cyc(0, '0, '0, 0, 0, '0, 0, '0);
    endtask

    // Complete random in-flight entries until the model is empty.
    task automatic drain();
        logic [3:0] ia, ib;
        for (int k = 0; k < 300 && m_q.size() > 0; k++) begin
            ia = m_q[$urandom_range(0, m_q.size() - 1)].idx;
            ib = m_q[$urandom_range(0, m_q.size() - 1)].idx;
            cyc(0, '0, '0, 0, 1, ia, 1, ib);
        end
        check("drain_left", 32'(m_q.size()), 32'd0);
        idle(3);
    endtask

    // Monitor: compare every presented retire against the next prediction.
    always @(negedge clk) begin
        ret_t r;
        if (started && (rif.retire_valid1 || rif.retire_valid2 || rif.retire_store != 2'b00)) begin
            ret_events++;
            ret_instr += int'(rif.retire_valid1) + int'(rif.retire_valid2)
                       + int'(rif.retire_store[0]) + int'(rif.retire_store[1]);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected: got v1=%0b v2=%0b st=%0b expected no retire at %0t",
                         rif.retire_valid1, rif.retire_valid2, rif.retire_store, $time);
            end else begin
                r = exp_q.pop_front();
                check("retire_valid1", 32'(rif.retire_valid1), 32'(r.v1));
                check("retire_valid2", 32'(rif.retire_valid2), 32'(r.v2));
                check("retire_store", 32'(rif.retire_store), 32'(r.st));
                check("retire_phys_reg1", 32'(rif.retire_phys_reg1), 32'(r.p1));
                check("retire_arch_reg1", 32'(rif.retire_arch_reg1), 32'(r.a1));
                check("retire_phys_reg2", 32'(rif.retire_phys_reg2), 32'(r.p2));
                check("retire_arch_reg2", 32'(rif.retire_arch_reg2), 32'(r.a2));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         base, base_i;
        logic [3:0] i0;
        logic [3:0] didx [40];
        bit         dv, cav, cbv;
        logic [3:0] ca, cb;

        reset                    = 1'b1;
        rif.dispatch_valid       = 1'b0;
        rif.dispatch_phys_rd     = '0;
        rif.dispatch_old_phys_rd = '0;
        rif.dispatch_arch_reg    = '0;
        rif.dispatch_is_store    = 1'b0;
        rif.complete_valid_a     = 1'b0;
        rif.complete_valid_b     = 1'b0;
        rif.complete_idx_a       = '0;
        rif.complete_idx_b       = '0;
        repeat (2) @(posedge clk);
        #1;
        started = 1;

        // Single ALU op
        base = ret_events;
        cyc(1, 6'd5, 5'd5, 0, 0, '0, 0, '0);
        cyc(0, '0, '0, 0, 1, 4'd0, 0, '0);
        idle(3);
        check("single_retire_cycles", 32'(ret_events - base), 32'd1);

        // Out-of-order completion, in-order retire
        base = ret_events;
        i0   = m_tail;
        cyc(1, 6'd1, 5'd1, 0, 0, '0, 0, '0);
        cyc(1, 6'd2, 5'd2, 0, 0, '0, 0, '0);
        cyc(1, 6'd3, 5'd3, 0, 0, '0, 0, '0);
        cyc(0, '0, '0, 0, 1, i0 + 4'd2, 0, '0);
        cyc(0, '0, '0, 0, 1, i0 + 4'd1, 0, '0);
        check("ooo_no_early_retire", 32'(ret_events - base), 32'd0);
        cyc(0, '0, '0, 0, 1, i0, 0, '0);
        idle(4);
        check("ooo_retire_cycles", 32'(ret_events - base), 32'd2);

        // Full buffer: 17th dispatch ignored, reopen after a retire
        for (int i = 0; i < 16; i++) cyc(1, 6'(i + 10), 5'(i), 0, 0, '0, 0, '0);
        cyc(1, 6'd60, 5'd30, 0, 0, '0, 0, '0);
        check("full_count", 32'(rif.rob_count), 32'd16);
        cyc(0, '0, '0, 0, 1, m_q[0].idx, 0, '0);
        idle(3);
        drain();

        // Wrap: 40 instructions, completion two cycles after dispatch
        base_i = ret_instr;
        for (int i = 0; i < 42; i++) begin
            dv  = (i < 40);
            cav = (i >= 2);
            ca  = (i >= 2) ? didx[i - 2] : 4'd0;
            if (dv) didx[i] = m_tail;
            cyc(dv, 6'(i), 5'(i % 32), 0, cav, ca, 0, '0);
        end
        idle(4);
        check("wrap_retired", 32'(ret_instr - base_i), 32'd40);

        // Store followed by ALU, completed together
        i0 = m_tail;
        cyc(1, 6'd9, 5'd3, 1, 0, '0, 0, '0);
        cyc(1, 6'd7, 5'd4, 0, 0, '0, 0, '0);
        cyc(0, '0, '0, 0, 1, i0, 1, i0 + 4'd1);
        idle(3);

        // Reset with entries in flight and a completion pending
        for (int i = 0; i < 5; i++) cyc(1, 6'(i + 20), 5'(i), 0, 0, '0, 0, '0);
        base = ret_events;
        step(1'b1, 0, '0, '0, 0, 1, m_q[0].idx, 0, '0);
        cyc(1, 6'd11, 5'd11, 0, 0, '0, 0, '0);
        idle(2);
        check("reset_no_retire", 32'(ret_events - base), 32'd0);
        drain();

        // Randomised traffic with occasional reset
        for (int i = 0; i < 800; i++) begin
            dv  = ($urandom_range(0, 9) < 7);
            cav = ($urandom_range(0, 3) != 0);
            cbv = ($urandom_range(0, 2) == 0);
            ca  = (m_q.size() > 0 && $urandom_range(0, 4) != 0)
                  ? m_q[$urandom_range(0, m_q.size() - 1)].idx : 4'($urandom);
            cb  = (m_q.size() > 0 && $urandom_range(0, 4) != 0)
                  ? m_q[$urandom_range(0, m_q.size() - 1)].idx : 4'($urandom);
            if ($urandom_range(0, 299) == 0)
                step(1'b1, dv, 6'($urandom), 5'($urandom), 0, cav, ca, cbv, cb);
            else
                cyc(dv, 6'($urandom), 5'($urandom), ($urandom_range(0, 4) == 0),
                    cav, ca, cbv, cb);
        end
        drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
